time_entry: RTL and testbench

TIME_ENTRY -- requirements
Module: time_entry

---
 rtl/time_entry.sv | 177 +++++++++++++++++
 tb/tb_time_entry.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_entry.sv
// Keypad time-entry FSM: collects HH:MM digits, validates them,
// and holds a load request for the time-keeping block.
module time_entry #(
  parameter logic [26:0] TIMEOUT  = 27'd100000000,
  parameter logic [26:0] SET_HOLD = 27'd110000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_minute,
  output logic [5:0] key_hour,
  output logic [5:0] key_minute,
  output logic       set_time,
  output logic       busy,
  output logic       err,
  output logic [2:0] digit_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    H1,
    M10,
    M1,
    CHECK,
    SET
  } state_e;

  localparam logic [3:0] SKIP   = 4'hA;
  localparam logic [3:0] CANCEL = 4'hB;

  state_e          state_q, state_d;
  logic            kv_q, kv_d;
  logic [3:0]      kc_q, kc_d;
  logic [3:0][3:0] slot_q, slot_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [26:0]     tmo_q, tmo_d;
  logic [26:0]     hold_q, hold_d;
  logic [5:0]      kh_q, kh_d;
  logic [5:0]      km_q, km_d;
  logic            err_q, err_d;

  logic       key_acc;
  logic       key_can;
  logic [6:0] ch, cm;
  logic [6:0] ht, hu, mt, mu;
  logic [6:0] hour, minute;
  logic       entry_ok;

  assign key_acc = kv_q && (kc_q <= SKIP);
  assign key_can = kv_q && (kc_q == CANCEL);

  // Skipped slots take the matching digit of the live time.
  always_comb begin
    ch = {1'b0, cur_hour};
    cm = {1'b0, cur_minute};
    ht = (slot_q[0] == SKIP) ? ch / 7'd10 : {3'b000, slot_q[0]};
    hu = (slot_q[1] == SKIP) ? ch % 7'd10 : {3'b000, slot_q[1]};
    mt = (slot_q[2] == SKIP) ? cm / 7'd10 : {3'b000, slot_q[2]};
    mu = (slot_q[3] == SKIP) ? cm % 7'd10 : {3'b000, slot_q[3]};
    hour     = ht * 7'd10 + hu;
    minute   = mt * 7'd10 + mu;
    entry_ok = (hour <= 7'd23) && (minute <= 7'd59);
  end

  always_comb begin
    state_d = state_q;
    kv_d    = key_valid;
    kc_d    = key_code;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    hold_d  = hold_q;
    kh_d    = kh_q;
    km_d    = km_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (key_acc) begin
          slot_d[0] = kc_q;
          err_d     = 1'b0;
          cnt_d     = 3'd1;
          tmo_d     = '0;
          state_d   = H1;
        end
      end
      H1, M10, M1: begin
        if (key_can) begin
          slot_d  = '0;
          cnt_d   = 3'd0;
          tmo_d   = '0;
          state_d = IDLE;
        end else if (key_acc) begin
          slot_d[cnt_q[1:0]] = kc_q;
          cnt_d = cnt_q + 3'd1;
          tmo_d = '0;
          unique case (1'b1)
            state_q == H1:  state_d = M10;
            state_q == M10: state_d = M1;
            default:        state_d = CHECK;
          endcase
        end else if (tmo_q == TIMEOUT - 27'd1) begin
          slot_d  = '0;
          cnt_d   = 3'd0;
          tmo_d   = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 27'd1;
        end
      end
      CHECK: begin
        if (entry_ok) begin
          kh_d    = hour[5:0];
          km_d    = minute[5:0];
          hold_d  = '0;
          state_d = SET;
        end else begin
          err_d   = 1'b1;
          slot_d  = '0;
          cnt_d   = 3'd0;
          state_d = IDLE;
        end
      end
      SET: begin
        if (hold_q == SET_HOLD - 27'd1) begin
          hold_d  = '0;
          slot_d  = '0;
          cnt_d   = 3'd0;
          state_d = IDLE;
        end else begin
          hold_d = hold_q + 27'd1;
        end
      end
      default: begin
        slot_d  = '0;
        cnt_d   = 3'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      kv_q    <= 1'b0;
      kc_q    <= 4'h0;
      slot_q  <= '0;
      cnt_q   <= 3'd0;
      tmo_q   <= '0;
      hold_q  <= '0;
      kh_q    <= 6'd0;
      km_q    <= 6'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kv_q    <= kv_d;
      kc_q    <= kc_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
      kh_q    <= kh_d;
      km_q    <= km_d;
      err_q   <= err_d;
    end
  end

  assign key_hour   = kh_q;
  assign key_minute = km_q;
  assign set_time   = (state_q == SET);
  assign busy       = (state_q != IDLE);
  assign err        = err_q;
  assign digit_cnt  = cnt_q;

endmodule

// File: tb/tb_time_entry.sv
// Bench for time_entry: scoreboard of expected HH:MM loads
// checked on each set_time rising edge, plus per-scenario checks.
module tb_time_entry;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'hF;
  logic [5:0] cur_hour = 6'd0;
  logic [5:0] cur_minute = 6'd0;
  logic [5:0] key_hour;
  logic [5:0] key_minute;
  logic       set_time;
  logic       busy;
  logic       err;
  logic [2:0] digit_cnt;

  int vecs = 0;
  int errs = 0;
  logic [11:0] sb_q[$];
  logic [11:0] sb_exp;
  logic        prev_set = 1'b0;
  logic [5:0]  last_h = 6'd0;
  logic [5:0]  last_m = 6'd0;

  always #5 clk = ~clk;

  time_entry #(
    .TIMEOUT (27'd20),
    .SET_HOLD(27'd8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .cur_hour  (cur_hour),
    .cur_minute(cur_minute),
    .key_hour  (key_hour),
    .key_minute(key_minute),
    .set_time  (set_time),
    .busy      (busy),
    .err       (err),
    .digit_cnt (digit_cnt)
  );

  // Scoreboard: every set_time rising edge consumes one expected load.
  always @(posedge clk) begin
    #1;
    if (set_time && !prev_set) begin
      vecs++;
      if (sb_q.size() == 0) begin
        errs++;
        $display("FAIL sb_unexpected_set got %0d:%0d expected none",
                 key_hour, key_minute);
      end else begin
        sb_exp = sb_q.pop_front();
        if ({key_hour, key_minute} !== sb_exp) begin
          errs++;
          $display("FAIL sb_load got %0d:%0d expected %0d:%0d",
                   key_hour, key_minute, sb_exp[11:6], sb_exp[5:0]);
        end
      end
    end
    prev_set = set_time;
  end

  task automatic send_key(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'hF;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL %s_idle_timeout busy=%b expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    #12;
    vecs++;
    if ({set_time, busy, err, digit_cnt, key_hour, key_minute} !== '0) begin
      errs++;
      $display("FAIL reset_state set=%b busy=%b err=%b cnt=%0d %0d:%0d expected all 0",
               set_time, busy, err, digit_cnt, key_hour, key_minute);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_release busy=%b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    int n;
    send_key(4'd1);
    send_key(4'd2);
    send_key(4'd3);
    sb_q.push_back({6'd12, 6'd34});
    send_key(4'd4);
    @(posedge clk);
    #1;
    vecs++;
    if (set_time !== 1'b0 || busy !== 1'b1 || digit_cnt !== 3'd4) begin
      errs++;
      $display("FAIL basic_check_cycle set=%b busy=%b cnt=%0d expected 0 1 4",
               set_time, busy, digit_cnt);
    end
    @(posedge clk);
    #1;
    vecs++;
    if (set_time !== 1'b1 || key_hour !== 6'd12 || key_minute !== 6'd34 ||
        err !== 1'b0) begin
      errs++;
      $display("FAIL basic_load set=%b %0d:%0d err=%b expected 1 12:34 0",
               set_time, key_hour, key_minute, err);
    end
    n = 1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (!set_time) break;
      n++;
      vecs++;
      if (busy !== 1'b1 || digit_cnt !== 3'd4) begin
        errs++;
        $display("FAIL basic_busy_in_set busy=%b cnt=%0d expected 1 4",
                 busy, digit_cnt);
      end
    end
    vecs++;
    if (n != 8) begin
      errs++;
      $display("FAIL basic_pulse_len got %0d expected 8", n);
    end
    vecs++;
    if (busy !== 1'b0 || digit_cnt !== 3'd0) begin
      errs++;
      $display("FAIL basic_after busy=%b cnt=%0d expected 0 0", busy, digit_cnt);
    end
    last_h = 6'd12;
    last_m = 6'd34;
  endtask

  task automatic test_invalid();
    logic [15:0] tbl [3];
    tbl[0] = 16'h2500;
    tbl[1] = 16'h2400;
    tbl[2] = 16'h1260;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) send_key(tbl[i][15-4*k -: 4]);
      repeat (2) @(posedge clk);
      #1;
      vecs++;
      if (err !== 1'b1 || set_time !== 1'b0 || busy !== 1'b0 ||
          key_hour !== last_h || key_minute !== last_m) begin
        errs++;
        $display("FAIL invalid_%0h err=%b set=%b busy=%b %0d:%0d expected 1 0 0 %0d:%0d",
                 tbl[i], err, set_time, busy, key_hour, key_minute, last_h, last_m);
      end
      repeat (12) @(posedge clk);
    end
  endtask

  task automatic test_skip();
    int n;
    cur_hour   = 6'd17;
    cur_minute = 6'd45;
    send_key(4'hA);
    @(posedge clk);
    #1;
    vecs++;
    if (err !== 1'b0 || digit_cnt !== 3'd1) begin
      errs++;
      $display("FAIL skip_first_key err=%b cnt=%0d expected 0 1", err, digit_cnt);
    end
    send_key(4'hA);
    send_key(4'd0);
    sb_q.push_back({6'd17, 6'd9});
    send_key(4'd9);
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if (key_hour !== 6'd17 || key_minute !== 6'd9 || set_time !== 1'b1) begin
      errs++;
      $display("FAIL skip_load %0d:%0d set=%b expected 17:9 1",
               key_hour, key_minute, set_time);
    end
    n = 1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (!set_time) break;
      n++;
    end
    vecs++;
    if (n != 8) begin
      errs++;
      $display("FAIL skip_pulse_len got %0d expected 8", n);
    end
    cur_hour   = 6'd6;
    cur_minute = 6'd7;
    repeat (3) send_key(4'hA);
    sb_q.push_back({6'd6, 6'd7});
    send_key(4'hA);
    wait_idle("skip_all");
    last_h = 6'd6;
    last_m = 6'd7;
  endtask

  task automatic test_cancel();
    send_key(4'd1);
    send_key(4'hB);
    @(posedge clk);
    #1;
    vecs++;
    if (busy !== 1'b0 || digit_cnt !== 3'd0 || err !== 1'b0) begin
      errs++;
      $display("FAIL cancel busy=%b cnt=%0d err=%b expected 0 0 0",
               busy, digit_cnt, err);
    end
    send_key(4'd0);
    send_key(4'd8);
    send_key(4'd3);
    sb_q.push_back({6'd8, 6'd30});
    send_key(4'd0);
    wait_idle("cancel");
    vecs++;
    if (key_hour !== 6'd8 || key_minute !== 6'd30) begin
      errs++;
      $display("FAIL cancel_final %0d:%0d expected 8:30", key_hour, key_minute);
    end
    last_h = 6'd8;
    last_m = 6'd30;
  endtask

  task automatic test_timeout();
    send_key(4'd1);
    send_key(4'd2);
    @(posedge clk);
    #1;
    vecs++;
    if (digit_cnt !== 3'd2 || busy !== 1'b1) begin
      errs++;
      $display("FAIL timeout_entry cnt=%0d busy=%b expected 2 1", digit_cnt, busy);
    end
    repeat (18) @(posedge clk);
    #1;
    vecs++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL timeout_early busy=%b expected 1", busy);
    end
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if (busy !== 1'b0 || err !== 1'b0 || digit_cnt !== 3'd0 ||
        set_time !== 1'b0 || key_hour !== last_h || key_minute !== last_m) begin
      errs++;
      $display("FAIL timeout_expired busy=%b err=%b cnt=%0d set=%b %0d:%0d expected 0 0 0 0 %0d:%0d",
               busy, err, digit_cnt, set_time, key_hour, key_minute, last_h, last_m);
    end
  endtask

  task automatic test_ignore_keys();
    send_key(4'd2);
    send_key(4'd3);
    send_key(4'd5);
    sb_q.push_back({6'd23, 6'd59});
    send_key(4'd9);
    send_key(4'hB);
    send_key(4'd5);
    wait_idle("ignore");
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if (key_hour !== 6'd23 || key_minute !== 6'd59 || busy !== 1'b0 ||
        digit_cnt !== 3'd0 || err !== 1'b0) begin
      errs++;
      $display("FAIL ignore_keys %0d:%0d busy=%b cnt=%0d err=%b expected 23:59 0 0 0",
               key_hour, key_minute, busy, digit_cnt, err);
    end
    last_h = 6'd23;
    last_m = 6'd59;
  endtask

  task automatic test_reset_mid_set();
    send_key(4'd1);
    send_key(4'd0);
    send_key(4'd1);
    sb_q.push_back({6'd10, 6'd15});
    send_key(4'd5);
    repeat (4) @(posedge clk);
    #2;
    vecs++;
    if (set_time !== 1'b1) begin
      errs++;
      $display("FAIL rst_pre set=%b expected 1", set_time);
    end
    rst = 1'b0;
    #1;
    vecs++;
    if (set_time !== 1'b0 || key_hour !== 6'd0 || key_minute !== 6'd0 ||
        busy !== 1'b0) begin
      errs++;
      $display("FAIL rst_mid_set set=%b %0d:%0d busy=%b expected 0 0:0 0",
               set_time, key_hour, key_minute, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    vecs++;
    if (busy !== 1'b0 || set_time !== 1'b0 || digit_cnt !== 3'd0) begin
      errs++;
      $display("FAIL rst_release busy=%b set=%b cnt=%0d expected 0 0 0",
               busy, set_time, digit_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_skip();
    test_cancel();
    test_timeout();
    test_ignore_keys();
    test_reset_mid_set();
    vecs++;
    if (sb_q.size() != 0) begin
      errs++;
      $display("FAIL sb_leftover got %0d pending expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
